// File: rtl/down_count.sv
// down_count: presettable '191-style up/down counter with terminal-count flag and ripple clock.
// mux2to1 picks per-digit presets and also forms the down-count wrap value.
module mux2to1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module down_count #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up_down,
    input  logic             cten,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             max_min
);
    logic [WIDTH-1:0] q_q, q_d, dn_val, up_val, dec_val;
    assign dec_val = q_q - WIDTH'(1);
    mux2to1 #(.WIDTH(WIDTH)) u_wrap (
        .in0 (dec_val),
        .in1 (d),
        .sel (q_q == '0),
        .out (dn_val)
    );
    always_comb begin
        up_val = (q_q < d) ? q_q + WIDTH'(1) : '0;
        q_d    = cten ? q_q : (up_down ? dn_val : up_val);
    end
    // Load is edge-triggered so ripple-clocked upper digits preload without their own clock.
    always_ff @(posedge clk or negedge reset or posedge load) begin
        if (!reset)
            q_q <= '0;
        else if (load)
            q_q <= d;
        else
            q_q <= q_d;
    end
    assign q       = q_q;
    assign max_min = up_down ? (q_q == '0) : (q_q == d);
    assign rco     = ~(max_min & ~cten & ~clk);
endmodule

// File: tb/tb_down_count.sv
// tb_down_count: directed checks of down_count and mux2to1 with hand-computed expectations.
module tb_down_count;
    logic       clk, reset, load, up_down, cten, rco, max_min, sel;
    logic [3:0] d, q, in0, in1, mout;
    int         vectors = 0;
    int         errs = 0;
    int         exp;

    down_count #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .load(load), .d(d), .up_down(up_down),
        .cten(cten), .q(q), .rco(rco), .max_min(max_min)
    );
    mux2to1 #(.WIDTH(4)) u_mux (.in0(in0), .in1(in1), .sel(sel), .out(mout));

    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        clk = 0; reset = 0; load = 1; d = 9; up_down = 1; cten = 1;
        in0 = 4; in1 = 9; sel = 0;
        #1;
        chk("reset_q", int'(q), 0);
        tick();
        tick();
        chk("reset_q_clk", int'(q), 0);
        chk("reset_maxmin", int'(max_min), 1);
        chk("reset_rco", int'(rco), 1);
        load = 0;
        #1;
        reset = 1;
        #2;
        chk("release_q", int'(q), 0);
        // asynchronous load, then down count with wrap to preset
        load = 1;
        #2;
        chk("async_load", int'(q), 9);
        load = 0; cten = 0; up_down = 1;
        #1;
        exp = 9;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (exp == 0) ? 9 : exp - 1;
            chk($sformatf("down_q%0d", i), int'(q), exp);
            chk($sformatf("down_mm%0d", i), int'(max_min), (exp == 0) ? 1 : 0);
            chk($sformatf("down_rco%0d", i), int'(rco), (exp == 0) ? 0 : 1);
        end
        // hold
        d = 5; load = 1;
        #2;
        load = 0; cten = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_q%0d", i), int'(q), 5);
        end
        reset = 0;
        #1;
        reset = 1;
        #1;
        chk("hold_zero_q", int'(q), 0);
        chk("hold_zero_mm", int'(max_min), 1);
        chk("hold_zero_rco", int'(rco), 1);
        tick();
        chk("hold_zero_rco_clk", int'(rco), 1);
        // up count wrapping at d
        up_down = 0; cten = 0;
        #1;
        exp = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = (exp < 5) ? exp + 1 : 0;
            chk($sformatf("up_q%0d", i), int'(q), exp);
            chk($sformatf("up_mm%0d", i), int'(max_min), (exp == 5) ? 1 : 0);
            chk($sformatf("up_rco%0d", i), int'(rco), (exp == 5) ? 0 : 1);
        end
        tick();
        tick();
        chk("up_before_reset", int'(q), 2);
        // reset mid-operation, and reset wins over load
        reset = 0;
        #1;
        chk("mid_reset_q", int'(q), 0);
        d = 7; load = 1;
        #1;
        chk("reset_over_load", int'(q), 0);
        tick();
        chk("reset_over_load_clk", int'(q), 0);
        reset = 1;
        #1;
        tick();
        chk("load_level_capture", int'(q), 7);
        d = 3;
        #2;
        chk("load_d_untracked", int'(q), 7);
        tick();
        chk("load_recapture", int'(q), 3);
        tick();
        chk("load_suppress_count", int'(q), 3);
        // direction change re-evaluates flag only
        load = 0; up_down = 0;
        #1;
        chk("dir_up_mm", int'(max_min), 1);
        up_down = 1;
        #1;
        chk("dir_down_mm", int'(max_min), 0);
        tick();
        chk("dir_down_q", int'(q), 2);
        // mux2to1
        sel = 0;
        #1;
        chk("mux_sel0", int'(mout), 4);
        sel = 1;
        #1;
        chk("mux_sel1", int'(mout), 9);
        in1 = 12;
        #1;
        chk("mux_follow", int'(mout), 12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
